// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
// Branch type codes, BTB update packet layout and FSM states.
package branch_resolve_unit_pkg;

    localparam logic [1:0] BTYPE_COND = 2'd0;
    localparam logic [1:0] BTYPE_CALL = 2'd1;
    localparam logic [1:0] BTYPE_RET  = 2'd2;
    localparam logic [1:0] BTYPE_ABS  = 2'd3;

    localparam int BRU_ADDR_W          = 32;
    localparam int SIZE_OF_BRANCH_INFO = BRU_ADDR_W + 3;
    localparam int BRANCH_INFO_DIR     = SIZE_OF_BRANCH_INFO - 1;
    localparam int BRANCH_INFO_TYP_HI  = SIZE_OF_BRANCH_INFO - 2;
    localparam int BRANCH_INFO_TYP_LO  = SIZE_OF_BRANCH_INFO - 3;
    localparam int BRANCH_INFO_TAR_HI  = BRU_ADDR_W - 1;
    localparam int BRANCH_INFO_TAR_LO  = 0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_DS  = 2'd1,
        S_REDIRECT = 2'd2
    } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/ID side bundle of the branch resolve unit.
// master drives predictions and resolutions, slave is the unit.
interface branch_resolve_unit_if #(
    parameter int ADDR_W = 32
) ();

    logic              pred_valid;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_hit;
    logic [1:0]        pred_type;
    logic [ADDR_W-1:0] pred_tar;
    logic              res_valid;
    logic [ADDR_W-1:0] res_pc;
    logic              res_is_branch;
    logic              res_dir;
    logic [1:0]        res_type;
    logic [ADDR_W-1:0] res_tar;
    logic              fifo_full;
    logic              branch_info_valid;
    logic              branch_info_dir;
    logic [1:0]        branch_info_typ;
    logic [ADDR_W-1:0] branch_info_tar;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output pred_valid, pred_pc, pred_hit, pred_type, pred_tar,
        output res_valid, res_pc, res_is_branch, res_dir, res_type, res_tar,
        input  fifo_full, branch_info_valid, branch_info_dir,
        input  branch_info_typ, branch_info_tar, mispredict, redirect_pc
    );

    modport slave (
        input  pred_valid, pred_pc, pred_hit, pred_type, pred_tar,
        input  res_valid, res_pc, res_is_branch, res_dir, res_type, res_tar,
        output fifo_full, branch_info_valid, branch_info_dir,
        output branch_info_typ, branch_info_tar, mispredict, redirect_pc
    );

endinterface

// File: rtl/branch_resolve_unit_fifo.sv
// bru_pred_fifo: synchronous FIFO of in-flight fetch predictions.
// Clear beats push/pop; push when full and pop when empty are ignored.
module bru_pred_fifo
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + {{AW{1'b0}}, do_push}
                       - {{AW{1'b0}}, do_pop};
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !(rst || clear)) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: checks fetch predictions, updates BTB, redirects.
// Optional BRU_PERF_CNT_EN adds saturating update/redirect counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0] perf_branch_cnt,
    output logic [31:0] perf_mispred_cnt,
`endif
    branch_resolve_unit_if.slave bus
);

    localparam int EW = 2 * ADDR_W + 3;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bru_state_e        state_q;
    logic [EW-1:0]     head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_pc;
    logic [ADDR_W-1:0] head_tar;
    logic              head_hit;
    logic [1:0]        head_typ;
    logic              go;
    logic              acc;
    logic              idle_acc;
    logic              fifo_push;
    logic              fifo_clear;
    logic              pred_taken;
    logic              act_taken;
    logic              mis;
    logic              upd_fire;
    logic              redir_fire;
    logic              unused_bits;

    logic              biv_q;
    logic              dir_q;
    logic [1:0]        typ_q;
    logic [ADDR_W-1:0] tar_q;
    logic              mispredict_q;
    logic [ADDR_W-1:0] redirect_pc_q;

    assign {head_pc, head_hit, head_typ, head_tar} = head;
    assign unused_bits = ^{head_typ, fifo_count};

    assign go         = !stall && !flush;
    assign acc        = bus.res_valid && go && (state_q != S_REDIRECT);
    assign idle_acc   = acc && (state_q == S_IDLE);
    assign fifo_push  = bus.pred_valid && go && (state_q != S_REDIRECT);
    assign fifo_clear = flush || (!stall && state_q == S_REDIRECT);

    // A PC mismatch means the head entry does not describe this instruction
    assign pred_taken = !fifo_empty && head_hit && (head_pc == bus.res_pc);
    assign act_taken  = bus.res_is_branch && bus.res_dir;
    assign mis = (pred_taken != act_taken)
              || (pred_taken && act_taken && head_tar != bus.res_tar);

    assign upd_fire   = idle_acc && bus.res_is_branch;
    assign redir_fire = (idle_acc && !bus.res_is_branch && mis)
                     || (acc && state_q == S_WAIT_DS);

    bru_pred_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (acc),
        .wdata ({bus.pred_pc, bus.pred_hit, bus.pred_type, bus.pred_tar}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Resolution FSM with registered update packet and redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            biv_q         <= 1'b0;
            dir_q         <= 1'b0;
            typ_q         <= '0;
            tar_q         <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else if (flush) begin
            state_q      <= S_IDLE;
            biv_q        <= 1'b0;
            mispredict_q <= 1'b0;
        end else if (!stall) begin
            biv_q        <= upd_fire;
            mispredict_q <= redir_fire;
            if (upd_fire) begin
                dir_q <= bus.res_dir;
                typ_q <= bus.res_type;
                tar_q <= bus.res_tar;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (idle_acc && mis) begin
                        if (bus.res_is_branch) begin
                            state_q       <= S_WAIT_DS;
                            redirect_pc_q <= act_taken ? bus.res_tar
                                           : bus.res_pc + ADDR_W'(8);
                        end else begin
                            state_q       <= S_REDIRECT;
                            redirect_pc_q <= bus.res_pc + ADDR_W'(4);
                        end
                    end
                end
                S_WAIT_DS: begin
                    if (acc) state_q <= S_REDIRECT;
                end
                S_REDIRECT: state_q <= S_IDLE;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.fifo_full         = fifo_full;
    assign bus.branch_info_valid = biv_q;
    assign bus.branch_info_dir   = dir_q;
    assign bus.branch_info_typ   = typ_q;
    assign bus.branch_info_tar   = tar_q;
    assign bus.mispredict        = mispredict_q;
    assign bus.redirect_pc       = redirect_pc_q;

`ifdef BRU_PERF_CNT_EN
    // Saturating event counters, frozen by stall, kept across flush
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branch_cnt  <= '0;
            perf_mispred_cnt <= '0;
        end else if (!stall) begin
            if (upd_fire && perf_branch_cnt != '1)
                perf_branch_cnt <= perf_branch_cnt + 32'd1;
            if (redir_fire && perf_mispred_cnt != '1)
                perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
        end
    end
`else
    // Counters are not built in this configuration
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases then random traffic.
// Reference model is a prediction queue plus a three-mode resolver.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.ADDR_W(AW)) bus ();

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branch_cnt;
    logic [31:0] perf_mispred_cnt;
    int          m_br_cnt = 0;
    int          m_mis_cnt = 0;
`endif

    branch_resolve_unit #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
`ifdef BRU_PERF_CNT_EN
        .perf_branch_cnt  (perf_branch_cnt),
        .perf_mispred_cnt (perf_mispred_cnt),
`endif
        .bus              (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] tar;
    } pred_t;

    typedef struct {
        int          kind;
        int          edge_no;
        logic        dir;
        logic [1:0]  typ;
        logic [31:0] val;
    } ev_t;

    typedef struct packed {
        logic        r;
        logic        f;
        logic        s;
        logic        pv;
        logic [31:0] ppc;
        logic        ph;
        logic [1:0]  pt;
        logic [31:0] ptar;
        logic        rv;
        logic [31:0] rpc;
        logic        rb;
        logic        rd;
        logic [1:0]  rt;
        logic [31:0] rtar;
    } stim_t;

    pred_t       mq[$];
    ev_t         eq[$];
    int          mode = 0;
    logic [31:0] pend_pc = '0;
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic [31:0] pc_ctr = 32'h2000;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Spec-level model: resolve against queue head, produce expected events
    task automatic model(input stim_t s, input int e);
        bit    full_now;
        bit    have;
        bit    ptk;
        bit    atk;
        bit    mis;
        pred_t h;
        full_now = (mq.size() == DEPTH);
        if (s.r || s.f) begin
            mq.delete();
            mode = 0;
`ifdef BRU_PERF_CNT_EN
            if (s.r) begin
                m_br_cnt  = 0;
                m_mis_cnt = 0;
            end
`endif
            return;
        end
        if (s.s) return;
        if (mode == 2) begin
            mq.delete();
            mode = 0;
            return;
        end
        if (s.rv) begin
            have = (mq.size() > 0);
            h = '{pc: '0, hit: 1'b0, tar: '0};
            if (have) h = mq.pop_front();
            if (mode == 1) begin
                mode = 2;
                eq.push_back('{kind: 1, edge_no: e, dir: 1'b0,
                               typ: 2'b0, val: pend_pc});
`ifdef BRU_PERF_CNT_EN
                m_mis_cnt++;
`endif
            end else begin
                ptk = have && h.hit && (h.pc == s.rpc);
                atk = s.rb && s.rd;
                mis = (ptk != atk) || (ptk && atk && h.tar != s.rtar);
                if (s.rb) begin
                    eq.push_back('{kind: 0, edge_no: e, dir: s.rd,
                                   typ: s.rt, val: s.rtar});
`ifdef BRU_PERF_CNT_EN
                    m_br_cnt++;
`endif
                end
                if (mis && s.rb) begin
                    mode = 1;
                    pend_pc = atk ? s.rtar : s.rpc + 32'd8;
                end else if (mis) begin
                    mode = 2;
                    eq.push_back('{kind: 1, edge_no: e, dir: 1'b0,
                                   typ: 2'b0, val: s.rpc + 32'd4});
`ifdef BRU_PERF_CNT_EN
                    m_mis_cnt++;
`endif
                end
            end
        end
        if (s.pv && !full_now)
            mq.push_back('{pc: s.ppc, hit: s.ph, tar: s.ptar});
    endtask

    task automatic step(input stim_t s);
        int e;
        if (!s.r)
            chk("fifo_full", {31'b0, bus.fifo_full},
                {31'b0, (mq.size() == DEPTH)});
        rst               = s.r;
        flush             = s.f;
        stall             = s.s;
        bus.pred_valid    = s.pv;
        bus.pred_pc       = s.ppc;
        bus.pred_hit      = s.ph;
        bus.pred_type     = s.pt;
        bus.pred_tar      = s.ptar;
        bus.res_valid     = s.rv;
        bus.res_pc        = s.rpc;
        bus.res_is_branch = s.rb;
        bus.res_dir       = s.rd;
        bus.res_type      = s.rt;
        bus.res_tar       = s.rtar;
        e = edge_n + 1;
        model(s, e);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic hit,
                        input logic [31:0] tar);
        stim_t s;
        s = '0;
        s.pv = 1'b1; s.ppc = pc; s.ph = hit;
        s.pt = BTYPE_COND; s.ptar = tar;
        step(s);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic br,
                           input logic dir, input logic [1:0] typ,
                           input logic [31:0] tar);
        stim_t s;
        s = '0;
        s.rv = 1'b1; s.rpc = pc; s.rb = br;
        s.rd = dir; s.rt = typ; s.rtar = tar;
        step(s);
    endtask

    task automatic idle(input int n);
        stim_t s;
        s = '0;
        for (int i = 0; i < n; i++) step(s);
    endtask

    task automatic take(input int kind, input logic dir,
                        input logic [1:0] typ, input logic [31:0] val);
        ev_t x;
        checks++;
        if (eq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind %0d edge %0d: got val %h, required no event",
                     kind, edge_n, val);
            return;
        end
        x = eq.pop_front();
        if (x.kind != kind || x.edge_no != edge_n || x.val !== val ||
            (kind == 0 && (x.dir !== dir || x.typ !== typ))) begin
            errors++;
            $display("FAIL event: got kind %0d edge %0d dir %b typ %0d val %h, required kind %0d edge %0d dir %b typ %0d val %h",
                     kind, edge_n, dir, typ, val,
                     x.kind, x.edge_no, x.dir, x.typ, x.val);
        end
    endtask

    // Monitor: one event per output change on an advancing edge
    initial begin : monitor
        bit adv;
        forever begin
            @(posedge clk);
            edge_n++;
            adv = !stall || flush || rst;
            @(negedge clk);
            if (adv && bus.branch_info_valid === 1'b1)
                take(0, bus.branch_info_dir, bus.branch_info_typ,
                     bus.branch_info_tar);
            if (adv && bus.mispredict === 1'b1)
                take(1, 1'b0, 2'b0, bus.redirect_pc);
        end
    end

    initial begin : stimulus
        stim_t s;
        s = '0;
        s.r = 1'b1;
        step(s);
        step(s);
        chk("rst_biv", {31'b0, bus.branch_info_valid}, 32'd0);
        chk("rst_misp", {31'b0, bus.mispredict}, 32'd0);
        chk("rst_full", {31'b0, bus.fifo_full}, 32'd0);
        chk("rst_rpc", bus.redirect_pc, 32'd0);
        chk("rst_tar", bus.branch_info_tar, 32'd0);
        chk("rst_typdir", {29'b0, bus.branch_info_typ, bus.branch_info_dir}, 32'd0);
        idle(1);

        push(32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b1, 1'b1, BTYPE_ABS, 32'h200);
        chk("t1_biv", {31'b0, bus.branch_info_valid}, 32'd1);
        chk("t1_tar", bus.branch_info_tar, 32'h200);
        chk("t1_misp", {31'b0, bus.mispredict}, 32'd0);
        idle(1);

        push(32'h100, 1'b0, 32'h0);
        resolve(32'h100, 1'b1, 1'b1, BTYPE_COND, 32'h300);
        resolve(32'h104, 1'b0, 1'b0, BTYPE_COND, 32'h0);
        chk("t2_misp", {31'b0, bus.mispredict}, 32'd1);
        chk("t2_rpc", bus.redirect_pc, 32'h300);
        idle(1);
        chk("t2_pulse_end", {31'b0, bus.mispredict}, 32'd0);

        push(32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b1, 1'b0, BTYPE_COND, 32'h0);
        resolve(32'h104, 1'b0, 1'b0, BTYPE_COND, 32'h0);
        chk("t3_rpc", bus.redirect_pc, 32'h108);
        idle(1);

        push(32'h400, 1'b1, 32'h500);
        resolve(32'h400, 1'b0, 1'b0, BTYPE_COND, 32'h0);
        chk("t4_misp", {31'b0, bus.mispredict}, 32'd1);
        chk("t4_rpc", bus.redirect_pc, 32'h404);
        chk("t4_biv", {31'b0, bus.branch_info_valid}, 32'd0);
        idle(1);

        push(32'hFFFF_FFFC, 1'b1, 32'h10);
        resolve(32'hFFFF_FFFC, 1'b1, 1'b0, BTYPE_COND, 32'h0);
        resolve(32'h0, 1'b0, 1'b0, BTYPE_COND, 32'h0);
        chk("wrap_rpc", bus.redirect_pc, 32'h4);
        idle(1);

        for (int i = 0; i < DEPTH; i++)
            push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
        chk("t5_full", {31'b0, bus.fifo_full}, 32'd1);
        push(32'h1000, 1'b1, 32'h999);
        chk("t5_still_full", {31'b0, bus.fifo_full}, 32'd1);
        resolve(32'h1000, 1'b0, 1'b0, BTYPE_COND, 32'h0);
        s = '0;
        s.pv = 1'b1; s.ppc = 32'h1010;
        s.rv = 1'b1; s.rpc = 32'h1004;
        step(s);
        chk("t5_not_full", {31'b0, bus.fifo_full}, 32'd0);
        push(32'h1014, 1'b0, 32'h0);
        chk("t5_refull", {31'b0, bus.fifo_full}, 32'd1);
        for (int i = 0; i < DEPTH; i++)
            resolve(32'h1008 + 32'(4 * i), 1'b0, 1'b0, BTYPE_COND, 32'h0);

        push(32'h100, 1'b0, 32'h0);
        resolve(32'h100, 1'b1, 1'b1, BTYPE_CALL, 32'h300);
        s = '0;
        s.f = 1'b1; s.rv = 1'b1; s.rpc = 32'h104;
        step(s);
        idle(2);
        chk("t6_flush_misp", {31'b0, bus.mispredict}, 32'd0);
        resolve(32'h500, 1'b0, 1'b0, BTYPE_COND, 32'h0);

        push(32'h100, 1'b0, 32'h0);
        resolve(32'h100, 1'b1, 1'b1, BTYPE_RET, 32'h300);
        s = '0;
        s.r = 1'b1; s.rv = 1'b1; s.rpc = 32'h104;
        step(s);
        chk("t6_rst_rpc", bus.redirect_pc, 32'h0);
        idle(2);
        resolve(32'h500, 1'b0, 1'b0, BTYPE_COND, 32'h0);

        push(32'h100, 1'b0, 32'h0);
        resolve(32'h100, 1'b1, 1'b1, BTYPE_COND, 32'h300);
        for (int i = 0; i < 3; i++) begin
            s = '0;
            s.s = 1'b1; s.rv = 1'b1; s.rpc = 32'h104;
            s.pv = 1'b1; s.ppc = 32'h108; s.ph = 1'b1;
            step(s);
        end
        chk("t6_stall_misp", {31'b0, bus.mispredict}, 32'd0);
        resolve(32'h104, 1'b0, 1'b0, BTYPE_COND, 32'h0);
        chk("t6_stall_redir", {31'b0, bus.mispredict}, 32'd1);
        chk("t6_stall_rpc", bus.redirect_pc, 32'h300);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.r    = ($urandom_range(0, 199) == 0);
            s.f    = ($urandom_range(0, 59) == 0);
            s.s    = ($urandom_range(0, 9) == 0);
            s.pv   = ($urandom_range(0, 1) == 1);
            s.ppc  = pc_ctr;
            if (s.pv) pc_ctr = pc_ctr + 32'd4;
            s.ph   = ($urandom_range(0, 1) == 1);
            s.pt   = 2'($urandom_range(0, 3));
            s.ptar = 32'h200 + 32'($urandom_range(0, 2) * 256);
            s.rv   = ($urandom_range(0, 9) < 4);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                s.rpc = mq[0].pc;
            else
                s.rpc = pc_ctr + 32'($urandom_range(0, 7) * 4);
            s.rb   = ($urandom_range(0, 1) == 1);
            s.rd   = ($urandom_range(0, 1) == 1);
            s.rt   = 2'($urandom_range(0, 3));
            s.rtar = 32'h200 + 32'($urandom_range(0, 2) * 256);
            step(s);
        end

        idle(4);
        chk("leftover_events", 32'(eq.size()), 32'd0);
`ifdef BRU_PERF_CNT_EN
        chk("perf_branch", perf_branch_cnt, 32'(m_br_cnt));
        chk("perf_mispred", perf_mispred_cnt, 32'(m_mis_cnt));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
